// File: rtl/counter_xn.sv
`default_nettype none
// ============================================================================
// Module   : counter_xn
// Purpose  : N_CH-channel down-counter/timer. Each channel has a count, a
//            reload register, a compare register and a mode (stop, one-shot,
//            periodic, PWM). Counting is paced by a per-channel tick enable.
//            Writes use the counter_we / counter_ch / reg_sel / counter_val
//            path; counter_out reads back the count of channel counter_ch.
// Ports    : clk           system clock, rising edge
//            rst           asynchronous active-high reset
//            tick[N_CH]    per-channel count enable (one clk wide)
//            counter_we    write strobe
//            counter_ch    channel select for write and read
//            reg_sel       00 reload, 01 compare, 10 control, 11 reserved
//            counter_val   write data
//            counter_out   count of channel counter_ch (0 if out of range)
//            counter_done  sticky per-channel terminal flags
//            pwm_out       per-channel PWM level
//            irq           (only with COUNTER_XN_IRQ_EN) registered OR of
//                          done & interrupt-enable over all channels
// Options  : COUNTER_XN_IRQ_EN - adds control bit [3] (interrupt enable) and
//            the irq output. Undefined: no irq port, bit [3] ignored.
// Revision : 1.0 - initial release
// ============================================================================
module counter_xn #(
   parameter int N_CH    = 4,
   parameter int WIDTH   = 32,
   parameter int CH_BITS = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_CH-1:0]    tick,
   input  logic               counter_we,
   input  logic [CH_BITS-1:0] counter_ch,
   input  logic [1:0]         reg_sel,
   input  logic [WIDTH-1:0]   counter_val,
   output logic [WIDTH-1:0]   counter_out,
   output logic [N_CH-1:0]    counter_done,
   output logic [N_CH-1:0]    pwm_out
`ifdef COUNTER_XN_IRQ_EN
   ,
   output logic               irq
`endif
);

   localparam logic [1:0] c_mode_stop    = 2'b00;
   localparam logic [1:0] c_mode_oneshot = 2'b01;
   localparam logic [1:0] c_mode_period  = 2'b10;
   localparam logic [1:0] c_mode_pwm     = 2'b11;

   localparam logic [1:0] c_sel_reload   = 2'b00;
   localparam logic [1:0] c_sel_compare  = 2'b01;
   localparam logic [1:0] c_sel_ctrl     = 2'b10;

   localparam logic [WIDTH-1:0] c_one    = WIDTH'(1);

   // Per-channel counts gathered for the read-back mux.
   logic [N_CH-1:0][WIDTH-1:0] all_count;
`ifdef COUNTER_XN_IRQ_EN
   logic [N_CH-1:0]            all_ien;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [WIDTH-1:0] count_q, count_d;
         logic [WIDTH-1:0] reload_q, reload_d;
         logic [WIDTH-1:0] compare_q, compare_d;
         logic [1:0]       mode_q, mode_d;
         logic             done_q, done_d;
         logic             wr_hit;
         logic             take_tick;
         logic             done_set;
         logic             done_clr;
`ifdef COUNTER_XN_IRQ_EN
         logic             ien_q, ien_d;
`endif

         // Channels whose index exceeds N_CH never match, so out-of-range
         // writes fall through with no effect.
         assign wr_hit = counter_we && (counter_ch == CH_BITS'(gi));

         always_comb begin
            count_d   = count_q;
            reload_d  = reload_q;
            compare_d = compare_q;
            mode_d    = mode_q;
            done_set  = 1'b0;
            done_clr  = 1'b0;
            take_tick = tick[gi];
`ifdef COUNTER_XN_IRQ_EN
            ien_d     = ien_q;
`endif

            if (wr_hit) begin
               case (reg_sel)
                  c_sel_reload: begin
                     reload_d  = counter_val;
                     count_d   = counter_val;
                     // The write owns the count this cycle; the tick is lost.
                     take_tick = 1'b0;
                  end
                  c_sel_compare: begin
                     compare_d = counter_val;
                  end
                  c_sel_ctrl: begin
                     mode_d   = counter_val[1:0];
                     done_clr = counter_val[2];
`ifdef COUNTER_XN_IRQ_EN
                     ien_d    = counter_val[3];
`endif
                  end
                  default: begin
                  end
               endcase
            end

            // Compare and control writes leave the count alone, so a
            // coincident tick still advances under the mode held before the
            // write. This lets a terminal event land in the same cycle as a
            // write-1-to-clear, in which case the set below wins.
            if (take_tick) begin
               case (mode_q)
                  c_mode_stop: begin
                  end
                  c_mode_oneshot: begin
                     if (count_q > c_one) begin
                        count_d = count_q - c_one;
                     end else if (count_q == c_one) begin
                        count_d  = '0;
                        done_set = 1'b1;
                     end
                  end
                  default: begin
                     // Periodic and PWM: reload on 1 (terminal) or on 0
                     // (restart without a terminal event).
                     if (count_q > c_one) begin
                        count_d = count_q - c_one;
                     end else begin
                        count_d  = reload_q;
                        done_set = (count_q == c_one);
                     end
                  end
               endcase
            end

            done_d = done_set | (done_q & ~done_clr);
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               count_q   <= '0;
               reload_q  <= '0;
               compare_q <= '0;
               mode_q    <= c_mode_stop;
               done_q    <= 1'b0;
            end else begin
               count_q   <= count_d;
               reload_q  <= reload_d;
               compare_q <= compare_d;
               mode_q    <= mode_d;
               done_q    <= done_d;
            end
         end

`ifdef COUNTER_XN_IRQ_EN
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ien_q <= 1'b0;
            end else begin
               ien_q <= ien_d;
            end
         end
         assign all_ien[gi] = ien_q;
`endif

         assign all_count[gi]    = count_q;
         assign counter_done[gi] = done_q;
         assign pwm_out[gi]      = (mode_q == c_mode_pwm) &&
                                   (count_q != '0) &&
                                   (count_q <= compare_q);
      end
   endgenerate

   // Read-back mux; unmatched (out-of-range) selects return 0.
   always_comb begin
      counter_out = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (counter_ch == CH_BITS'(k)) begin
            counter_out = all_count[k];
         end
      end
   end

`ifdef COUNTER_XN_IRQ_EN
   logic irq_q, irq_d;

   assign irq_d = |(counter_done & all_ien);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_xn.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_xn
// Purpose  : Self-checking bench for counter_xn (N_CH=4, WIDTH=8, CH_BITS=3).
//            Directed scenarios plus a randomized run against a rule-level
//            model of every channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_xn;
   localparam int N_CH    = 4;
   localparam int WIDTH   = 8;
   localparam int CH_BITS = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [N_CH-1:0]    tick = '0;
   logic               counter_we = 1'b0;
   logic [CH_BITS-1:0] counter_ch = '0;
   logic [1:0]         reg_sel = '0;
   logic [WIDTH-1:0]   counter_val = '0;
   logic [WIDTH-1:0]   counter_out;
   logic [N_CH-1:0]    counter_done;
   logic [N_CH-1:0]    pwm_out;
`ifdef COUNTER_XN_IRQ_EN
   logic               irq;
`endif

   int total = 0;
   int bad   = 0;

   counter_xn #(.N_CH(N_CH), .WIDTH(WIDTH), .CH_BITS(CH_BITS)) dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .counter_we   (counter_we),
      .counter_ch   (counter_ch),
      .reg_sel      (reg_sel),
      .counter_val  (counter_val),
      .counter_out  (counter_out),
      .counter_done (counter_done),
      .pwm_out      (pwm_out)
`ifdef COUNTER_XN_IRQ_EN
      ,
      .irq          (irq)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference model (channel rules, plain integers) -------
   int m_cnt  [N_CH];
   int m_rel  [N_CH];
   int m_cmp  [N_CH];
   int m_mode [N_CH];
   bit m_done [N_CH];
   bit m_ien  [N_CH];
   bit m_irq;

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_cnt[c] = 0; m_rel[c] = 0; m_cmp[c] = 0; m_mode[c] = 0;
         m_done[c] = 0; m_ien[c] = 0;
      end
      m_irq = 0;
   endtask

   task automatic model_step(input bit we, input int ch, input int sel,
                             input int val, input logic [N_CH-1:0] tk);
      bit irq_next = 0;
      for (int c = 0; c < N_CH; c++) irq_next |= m_done[c] & m_ien[c];
      for (int c = 0; c < N_CH; c++) begin
         bit hit  = we && (ch == c);
         bit setd = 0;
         if (hit && sel == 0) begin
            m_cnt[c] = val;
            m_rel[c] = val;
         end else if (tk[c] && m_mode[c] != 0) begin
            if (m_cnt[c] >= 2) m_cnt[c] = m_cnt[c] - 1;
            else begin
               setd = (m_cnt[c] == 1);
               m_cnt[c] = (m_mode[c] == 1) ? 0 : m_rel[c];
            end
         end
         if (hit && sel == 1) m_cmp[c] = val;
         if (hit && sel == 2) begin
            m_mode[c] = val % 4;
            m_ien[c]  = (val / 8) % 2;
            if ((val / 4) % 2 == 1) m_done[c] = 0;
         end
         if (setd) m_done[c] = 1;
      end
      m_irq = irq_next;
   endtask

   function automatic logic [N_CH-1:0] exp_done();
      logic [N_CH-1:0] v;
      for (int c = 0; c < N_CH; c++) v[c] = m_done[c];
      return v;
   endfunction

   function automatic logic [N_CH-1:0] exp_pwm();
      logic [N_CH-1:0] v;
      for (int c = 0; c < N_CH; c++)
         v[c] = (m_mode[c] == 3) && (m_cnt[c] != 0) && (m_cnt[c] <= m_cmp[c]);
      return v;
   endfunction

   // ---------------- stimulus helpers ---------------------------------------
   // Apply inputs, take one edge, update the model, sample 1 time unit later.
   task automatic step(input bit we, input logic [CH_BITS-1:0] ch,
                       input logic [1:0] sel, input logic [WIDTH-1:0] val,
                       input logic [N_CH-1:0] tk);
      counter_we  = we;
      counter_ch  = ch;
      reg_sel     = sel;
      counter_val = val;
      tick        = tk;
      @(posedge clk);
      model_step(we, int'(ch), int'(sel), int'(val), tk);
      #1;
      counter_we = 1'b0;
      tick       = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      counter_we = 1'b0;
      tick = '0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------- scenarios ---------------------------------------------
   task automatic test_reset();
      apply_reset();
      for (int c = 0; c < N_CH; c++) begin
         counter_ch = CH_BITS'(c);
         #1;
         total++;
         if (counter_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_count ch%0d got %0h want 0", c, counter_out);
         end
      end
      total++;
      if (counter_done !== 4'h0 || pwm_out !== 4'h0) begin
         bad++;
         $display("FAIL reset_flags done=%b pwm=%b want 0000/0000", counter_done, pwm_out);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      step(1, 0, 2'b00, 8'd7, 4'b0000);
      step(1, 0, 2'b01, 8'd6, 4'b0000);
      step(1, 0, 2'b10, 8'h03, 4'b0000);
      step(1, 1, 2'b00, 8'd1, 4'b0000);
      step(1, 1, 2'b10, 8'h01, 4'b0000);
      step(0, 0, 2'b00, 8'd0, 4'b0011);
      step(0, 0, 2'b00, 8'd0, 4'b0001);
      total++;
      if (counter_out !== 8'h05 || pwm_out !== 4'b0001 || counter_done !== 4'b0010) begin
         bad++;
         $display("FAIL pre_reset out=%0h pwm=%b done=%b want 05/0001/0010",
                  counter_out, pwm_out, counter_done);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (counter_out !== 8'h00 || counter_done !== 4'h0 || pwm_out !== 4'h0) begin
         bad++;
         $display("FAIL async_reset out=%0h done=%b pwm=%b want 0/0000/0000",
                  counter_out, counter_done, pwm_out);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_oneshot();
      int exp_c [5] = '{2, 1, 0, 0, 0};
      apply_reset();
      step(1, 1, 2'b00, 8'd3, 4'b0000);
      step(1, 1, 2'b10, 8'h01, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 2'b00, 8'd0, 4'b0010);
         total++;
         if (counter_out !== 8'(exp_c[i]) || counter_done[1] !== (i >= 2)) begin
            bad++;
            $display("FAIL oneshot tick%0d count=%0d done=%b want %0d/%b",
                     i + 1, counter_out, counter_done[1], exp_c[i], (i >= 2));
         end
      end
      step(1, 1, 2'b10, 8'h05, 4'b0000);
      total++;
      if (counter_done !== 4'b0000 || counter_out !== 8'h00) begin
         bad++;
         $display("FAIL oneshot_clear done=%b count=%0d want 0000/0", counter_done, counter_out);
      end
   endtask

   task automatic test_periodic();
      int exp_c [9] = '{3, 2, 1, 4, 3, 2, 1, 4, 3};
      apply_reset();
      step(1, 2, 2'b00, 8'd4, 4'b0000);
      step(1, 2, 2'b10, 8'h02, 4'b0000);
      for (int i = 0; i < 9; i++) begin
         if (i == 7) step(1, 2, 2'b10, 8'h06, 4'b0100);
         else        step(0, 2, 2'b00, 8'd0,  4'b0100);
         total++;
         if (counter_out !== 8'(exp_c[i]) || counter_done[2] !== (i >= 3)) begin
            bad++;
            $display("FAIL periodic tick%0d count=%0d done=%b want %0d/%b",
                     i + 1, counter_out, counter_done[2], exp_c[i], (i >= 3));
         end
      end
   endtask

   task automatic test_pwm();
      logic [WIDTH-1:0] cmps [3] = '{8'd3, 8'd0, 8'd200};
      int               want [3] = '{6, 0, 20};
      apply_reset();
      step(1, 3, 2'b00, 8'd10, 4'b0000);
      step(1, 3, 2'b10, 8'h03, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         int highs = 0;
         step(1, 3, 2'b01, cmps[k], 4'b0000);
         for (int i = 0; i < 20; i++) begin
            step(0, 3, 2'b00, 8'd0, 4'b1000);
            if (pwm_out[3] === 1'b1) highs++;
         end
         total++;
         if (highs != want[k]) begin
            bad++;
            $display("FAIL pwm_duty cmp=%0d high=%0d want %0d", cmps[k], highs, want[k]);
         end
      end
   endtask

   task automatic test_collision_range();
      apply_reset();
      step(1, 0, 2'b00, 8'd5, 4'b0000);
      step(1, 0, 2'b10, 8'h02, 4'b0000);
      step(1, 0, 2'b00, 8'd9, 4'b0001);
      total++;
      if (counter_out !== 8'd9) begin
         bad++;
         $display("FAIL collision count=%0d want 9", counter_out);
      end
      step(1, 5, 2'b00, 8'h33, 4'b0000);
      step(1, 5, 2'b10, 8'h07, 4'b0000);
      total++;
      if (counter_out !== 8'h00) begin
         bad++;
         $display("FAIL range_read got %0h want 0", counter_out);
      end
      for (int c = 0; c < N_CH; c++) begin
         counter_ch = CH_BITS'(c);
         #1;
         total++;
         if (counter_out !== ((c == 0) ? 8'd9 : 8'd0)) begin
            bad++;
            $display("FAIL range_nochange ch%0d got %0d want %0d", c, counter_out,
                     (c == 0) ? 9 : 0);
         end
      end
      // Reserved register write is ignored; the coincident tick still counts.
      step(1, 0, 2'b11, 8'd1, 4'b0001);
      total++;
      if (counter_out !== 8'd8 || counter_done !== 4'h0 || pwm_out !== 4'h0) begin
         bad++;
         $display("FAIL reserved_sel count=%0d done=%b pwm=%b want 8/0000/0000",
                  counter_out, counter_done, pwm_out);
      end
   endtask

`ifdef COUNTER_XN_IRQ_EN
   task automatic test_irq();
      apply_reset();
      step(1, 0, 2'b00, 8'd1, 4'b0000);
      step(1, 0, 2'b10, 8'h01, 4'b0000);
      step(1, 1, 2'b00, 8'd1, 4'b0000);
      step(1, 1, 2'b10, 8'h09, 4'b0000);
      step(0, 0, 2'b00, 8'd0, 4'b0011);
      total++;
      if (counter_done !== 4'b0011 || irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_done_edge done=%b irq=%b want 0011/0", counter_done, irq);
      end
      step(0, 0, 2'b00, 8'd0, 4'b0000);
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("FAIL irq_rise irq=%b want 1", irq);
      end
      step(1, 1, 2'b10, 8'h0D, 4'b0000);
      total++;
      if (counter_done !== 4'b0001 || irq !== 1'b1) begin
         bad++;
         $display("FAIL irq_clear_edge done=%b irq=%b want 0001/1", counter_done, irq);
      end
      step(0, 0, 2'b00, 8'd0, 4'b0000);
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_fall irq=%b want 0", irq);
      end
   endtask
`endif

   task automatic test_random();
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         bit               we  = ($urandom_range(0, 3) == 0);
         logic [CH_BITS-1:0] ch = CH_BITS'($urandom_range(0, 7));
         logic [1:0]       sel = 2'($urandom_range(0, 3));
         logic [WIDTH-1:0] val;
         logic [N_CH-1:0]  tk  = N_CH'($urandom);
         logic [CH_BITS-1:0] rch;
         logic [WIDTH-1:0] want;
         case (sel)
            2'b00:   val = 8'($urandom_range(0, 12));
            2'b01:   val = 8'($urandom_range(0, 14));
            default: val = 8'($urandom_range(0, 15));
         endcase
         step(we, ch, sel, val, tk);
         rch = CH_BITS'($urandom_range(0, 7));
         counter_ch = rch;
         #1;
         want = (int'(rch) < N_CH) ? 8'(m_cnt[rch]) : 8'h00;
         total++;
         if (counter_out !== want) begin
            bad++;
            $display("FAIL rand_count cyc%0d ch%0d got %0d want %0d", n, rch, counter_out, want);
         end
         total++;
         if (counter_done !== exp_done()) begin
            bad++;
            $display("FAIL rand_done cyc%0d got %b want %b", n, counter_done, exp_done());
         end
         total++;
         if (pwm_out !== exp_pwm()) begin
            bad++;
            $display("FAIL rand_pwm cyc%0d got %b want %b", n, pwm_out, exp_pwm());
         end
`ifdef COUNTER_XN_IRQ_EN
         total++;
         if (irq !== m_irq) begin
            bad++;
            $display("FAIL rand_irq cyc%0d got %b want %b", n, irq, m_irq);
         end
`endif
      end
   endtask

   initial begin
      model_reset();
      rst = 1'b1;
      #12;
      rst = 1'b0;
      test_reset();
      test_async_reset();
      test_oneshot();
      test_periodic();
      test_pwm();
      test_collision_range();
`ifdef COUNTER_XN_IRQ_EN
      test_irq();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
